// File: rtl/param_cpu.sv
// -----------------------------------------------------------------------------
// param_cpu -- small parameterised accumulator CPU with a loadable
// instruction memory.
//
// Operation: en=1 moves IDLE->LOAD. In LOAD, instruction words arrive on
// codein/we_IM and fill the instruction memory from address 0 upward. start
// launches execution at pc=0. Each instruction takes two cycles (FETCH
// registers IM[pc], EXEC updates the registers and pc). Opcode F parks the
// core in HALT until en drops or rst is asserted.
//
// Parameters:
//   DATA_W  width of registers A/B and the ALU (>= 8)
//   IM_AW   instruction memory address width (2^IM_AW words of 16 bits)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         block enable; low returns to IDLE and clears pc/write pointer
//   we_IM      instruction-memory write strobe (honoured only in LOAD)
//   codein     instruction word to write
//   immd       reserved immediate bus (unused)
//   start      leave LOAD and begin executing at pc=0
//   za, zb     combinational A==0 / B==0
//   eq, gt, lt registered unsigned compare flags from the last CMP
//   pc         program counter
//   acc        register A
//   running    core is in FETCH or EXEC
//   halted     core is in HALT
//   load_full  every instruction-memory word has been written
//   cy         carry/borrow/shift-out flag (only with PARAM_CPU_CARRY_EN)
//
// Build option: define PARAM_CPU_CARRY_EN to add the cy output and its logic.
// -----------------------------------------------------------------------------
module param_cpu #(
  parameter int DATA_W = 8,
  parameter int IM_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we_IM,
  input  logic [15:0]       codein,
  input  logic [11:0]       immd,
  input  logic              start,
  output logic              za,
  output logic              zb,
  output logic              eq,
  output logic              gt,
  output logic              lt,
  output logic [IM_AW-1:0]  pc,
  output logic [DATA_W-1:0] acc,
  output logic              running,
  output logic              halted,
  output logic              load_full
`ifdef PARAM_CPU_CARRY_EN
  ,
  output logic              cy
`endif
);

  localparam int IM_DEPTH = 1 << IM_AW;

  localparam logic [IM_AW-1:0] PC_INC   = IM_AW'(1);
  localparam logic [IM_AW:0]   WPTR_INC = (IM_AW + 1)'(1);

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_SWAP = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IM_AW-1:0]    pc_q, pc_d;
  // One extra bit: the MSB set means the memory is full and further writes
  // are dropped instead of wrapping onto address 0.
  logic [IM_AW:0]      wptr_q, wptr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [15:0]         ir_q, ir_d;
  logic                eq_q, eq_d;
  logic                gt_q, gt_d;
  logic                lt_q, lt_d;
`ifdef PARAM_CPU_CARRY_EN
  logic                cy_q, cy_d;
`endif

  logic [15:0]         im_q [IM_DEPTH];
  logic                im_we_s;
  logic [3:0]          opcode_s;
  logic [DATA_W:0]     sum_s;
  logic [DATA_W:0]     diff_s;
  logic                unused_s;

  assign opcode_s = ir_q[15:12];
  // Extended add/sub: the extra MSB is the carry-out resp. borrow.
  assign sum_s    = {1'b0, a_q} + {1'b0, b_q};
  assign diff_s   = {1'b0, a_q} - {1'b0, b_q};
  // immd and the upper immediate nibble are intentionally not decoded.
  assign unused_s = ^{immd, ir_q[11:8], sum_s[DATA_W], diff_s[DATA_W]};

  // Next-state, datapath and memory-write decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    a_d     = a_q;
    b_d     = b_q;
    ir_d    = ir_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    im_we_s = 1'b0;
`ifdef PARAM_CPU_CARRY_EN
    cy_d    = cy_q;
`endif

    if (!en) begin
      // Disable overrides everything; A, B, flags and memory are retained.
      state_d = S_IDLE;
      pc_d    = '0;
      wptr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
        end

        S_LOAD: begin
          if (we_IM && !wptr_q[IM_AW]) begin
            im_we_s = 1'b1;
            wptr_d  = wptr_q + WPTR_INC;
          end else begin
            im_we_s = 1'b0;
          end
          // A write in the same cycle as start still lands above.
          if (start) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end else begin
            state_d = S_LOAD;
          end
        end

        S_FETCH: begin
          ir_d    = im_q[pc_q];
          state_d = S_EXEC;
        end

        S_EXEC: begin
          pc_d    = pc_q + PC_INC;
          state_d = S_FETCH;
          case (opcode_s)
            OP_LDA:  a_d = DATA_W'(ir_q[7:0]);
            OP_LDB:  b_d = DATA_W'(ir_q[7:0]);
            OP_ADD: begin
              a_d = sum_s[DATA_W-1:0];
`ifdef PARAM_CPU_CARRY_EN
              cy_d = sum_s[DATA_W];
`endif
            end
            OP_SUB: begin
              a_d = diff_s[DATA_W-1:0];
`ifdef PARAM_CPU_CARRY_EN
              cy_d = diff_s[DATA_W];
`endif
            end
            OP_AND:  a_d = a_q & b_q;
            OP_OR:   a_d = a_q | b_q;
            OP_XOR:  a_d = a_q ^ b_q;
            OP_CMP: begin
              eq_d = (a_q == b_q);
              gt_d = (a_q > b_q);
              lt_d = (a_q < b_q);
            end
            OP_JMP:  pc_d = ir_q[IM_AW-1:0];
            OP_JZ: begin
              if (a_q == '0) begin
                pc_d = ir_q[IM_AW-1:0];
              end else begin
                pc_d = pc_q + PC_INC;
              end
            end
            OP_SWAP: begin
              a_d = b_q;
              b_d = a_q;
            end
            OP_SHL: begin
              a_d = {a_q[DATA_W-2:0], 1'b0};
`ifdef PARAM_CPU_CARRY_EN
              cy_d = a_q[DATA_W-1];
`endif
            end
            OP_SHR: begin
              a_d = {1'b0, a_q[DATA_W-1:1]};
`ifdef PARAM_CPU_CARRY_EN
              cy_d = a_q[0];
`endif
            end
            OP_HALT: begin
              // pc stays on the HALT instruction.
              pc_d    = pc_q;
              state_d = S_HALT;
            end
            default: begin
              // NOP (0 and E): only pc advances.
              a_d = a_q;
            end
          endcase
        end

        S_HALT: begin
          state_d = S_HALT;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Architectural state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wptr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifdef PARAM_CPU_CARRY_EN
      cy_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
`ifdef PARAM_CPU_CARRY_EN
      cy_q    <= cy_d;
`endif
    end
  end

  // Instruction memory; deliberately not reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (im_we_s) begin
      im_q[wptr_q[IM_AW-1:0]] <= codein;
    end
  end

  assign za        = (a_q == '0);
  assign zb        = (b_q == '0);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign pc        = pc_q;
  assign acc       = a_q;
  assign running   = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign load_full = wptr_q[IM_AW];
`ifdef PARAM_CPU_CARRY_EN
  assign cy        = cy_q;
`endif

endmodule

// File: tb/tb_param_cpu.sv
// -----------------------------------------------------------------------------
// tb_param_cpu -- self-checking bench for param_cpu (DATA_W=8, IM_AW=4).
// Directed program table with constant expectations, hand-written sequences
// for timing/boundary cases, then random programs checked against an
// instruction-level reference model. Checks cy when PARAM_CPU_CARRY_EN is set.
// -----------------------------------------------------------------------------
module tb_param_cpu;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 256;

  logic        clk = 1'b0;
  logic        rst, en, we_IM, start;
  logic [15:0] codein;
  logic [11:0] immd;
  logic        za, zb, eq, gt, lt, running, halted, load_full;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
`ifdef PARAM_CPU_CARRY_EN
  logic        cy;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (instruction-set level).
  logic [15:0] m_mem [DEPTH];
  int m_a, m_b, m_pc, m_wptr;
  bit m_eq, m_gt, m_lt, m_cy, m_halt;

  logic [15:0] pbuf [17];
  int          plen;

  typedef struct {
    logic [15:0] w [6];
    int          n;
    int          cyc;
    logic [7:0]  acc;
    logic [3:0]  pc;
    logic        hlt;
    logic [2:0]  flg;   // {eq, gt, lt}
    logic        cy;
  } vec_t;
  vec_t tbl [$];

  param_cpu #(.DATA_W(DW), .IM_AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .we_IM(we_IM), .codein(codein),
    .immd(immd), .start(start), .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt),
    .pc(pc), .acc(acc), .running(running), .halted(halted),
    .load_full(load_full)
`ifdef PARAM_CPU_CARRY_EN
    , .cy(cy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] w0, w1, w2, w3, w4, w5, input int n, cyc,
                         input logic [7:0] a, input logic [3:0] p, input logic h,
                         input logic [2:0] f, input logic c);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.n = n; v.cyc = cyc; v.acc = a; v.pc = p; v.hlt = h; v.flg = f; v.cy = c;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_pc = 0; m_wptr = 0;
    m_eq = 0; m_gt = 0; m_lt = 0; m_cy = 0; m_halt = 0;
  endtask

  // Executes up to k instructions of the program held in m_mem.
  task automatic model_run(input int k);
    logic [15:0] ins;
    int op, t;
    for (int i = 0; i < k; i++) begin
      if (!m_halt) begin
        ins  = m_mem[m_pc];
        op   = int'(ins[15:12]);
        m_pc = (m_pc + 1) % DEPTH;
        case (op)
          1: m_a = int'(ins[7:0]);
          2: m_b = int'(ins[7:0]);
          3: begin t = m_a + m_b; m_cy = (t >= MOD); m_a = t % MOD; end
          4: begin m_cy = (m_a < m_b); m_a = (m_a - m_b + MOD) % MOD; end
          5: m_a = m_a & m_b;
          6: m_a = m_a | m_b;
          7: m_a = m_a ^ m_b;
          8: begin m_eq = (m_a == m_b); m_gt = (m_a > m_b); m_lt = (m_a < m_b); end
          9: m_pc = int'(ins[AW-1:0]);
          10: if (m_a == 0) m_pc = int'(ins[AW-1:0]);
          11: begin t = m_a; m_a = m_b; m_b = t; end
          12: begin m_cy = (m_a >= MOD / 2); m_a = (m_a * 2) % MOD; end
          13: begin m_cy = ((m_a % 2) == 1); m_a = m_a / 2; end
          15: begin m_pc = (m_pc + DEPTH - 1) % DEPTH; m_halt = 1; end
          default: ;
        endcase
      end
    end
  endtask

  // Drop en for a cycle, re-enable into LOAD and write pbuf[0..plen-1].
  task automatic load_buf();
    en = 1'b0; we_IM = 1'b0; start = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    m_pc = 0; m_wptr = 0; m_halt = 0;
    for (int i = 0; i < plen; i++) begin
      we_IM = 1'b1; codein = pbuf[i]; immd = 12'($urandom);
      @(negedge clk);
      if (m_wptr < DEPTH) begin
        m_mem[m_wptr] = pbuf[i];
        m_wptr++;
      end
    end
    we_IM = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0; m_halt = 0;
  endtask

  task automatic run_instr(input int k);
    repeat (2 * k) @(posedge clk);
    @(negedge clk);
    model_run(k);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".acc"}, 32'(acc), m_a);
    check({tag, ".pc"}, 32'(pc), m_pc);
    check({tag, ".flags"}, {29'd0, eq, gt, lt}, {29'd0, m_eq, m_gt, m_lt});
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".running"}, 32'(running), 32'(!m_halt));
    check({tag, ".za"}, 32'(za), 32'(m_a == 0));
    check({tag, ".zb"}, 32'(zb), 32'(m_b == 0));
    check({tag, ".load_full"}, 32'(load_full), 32'(m_wptr == DEPTH));
`ifdef PARAM_CPU_CARRY_EN
    check({tag, ".cy"}, 32'(cy), 32'(m_cy));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".acc"}, 32'(acc), 32'd0);
    check({tag, ".pc"}, 32'(pc), 32'd0);
    check({tag, ".za_zb"}, {30'd0, za, zb}, 32'd3);
    check({tag, ".flags"}, {29'd0, eq, gt, lt}, 32'd0);
    check({tag, ".status"}, {29'd0, running, halted, load_full}, 32'd0);
`ifdef PARAM_CPU_CARRY_EN
    check({tag, ".cy"}, 32'(cy), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; we_IM = 1'b0; start = 1'b0;
    codein = 16'h0000; immd = 12'h000;
    model_reset();

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ---- directed program table ----
    add_vec(16'h1005, 16'h2003, 16'h3000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'h08, 4'd3, 1'b1, 3'b000, 1'b0);
    add_vec(16'h1002, 16'h2005, 16'h4000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'hFD, 4'd3, 1'b1, 3'b000, 1'b1);
    add_vec(16'h1007, 16'h2007, 16'h8000, 16'h1009, 16'h8000, 16'hF000, 6, 12, 8'h09, 4'd5, 1'b1, 3'b010, 1'b1);
    add_vec(16'h1000, 16'hA005, 16'h0, 16'h0, 16'h0, 16'h0, 2,  4, 8'h00, 4'd5, 1'b0, 3'b010, 1'b1);
    add_vec(16'h10F3, 16'h2F0F, 16'h5000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'h03, 4'd3, 1'b1, 3'b010, 1'b1);
    add_vec(16'h10F3, 16'h2F0F, 16'h6000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'hFF, 4'd3, 1'b1, 3'b010, 1'b1);
    add_vec(16'h10F3, 16'h2F0F, 16'h7000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'hFC, 4'd3, 1'b1, 3'b010, 1'b1);
    add_vec(16'h1081, 16'hC000, 16'hC000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'h04, 4'd3, 1'b1, 3'b010, 1'b0);
    add_vec(16'h1081, 16'hD000, 16'hF000, 16'h0, 16'h0, 16'h0, 3,  6, 8'h40, 4'd2, 1'b1, 3'b010, 1'b1);
    add_vec(16'h10AA, 16'h2055, 16'hB000, 16'h8000, 16'hF000, 16'h0, 5, 10, 8'h55, 4'd4, 1'b1, 3'b001, 1'b1);
    add_vec(16'h1005, 16'h9003, 16'h1077, 16'h1033, 16'hF000, 16'h0, 5,  8, 8'h33, 4'd4, 1'b1, 3'b001, 1'b1);
    add_vec(16'h10FF, 16'h2001, 16'h3000, 16'hF000, 16'h0, 16'h0, 4,  8, 8'h00, 4'd3, 1'b1, 3'b001, 1'b1);

    for (int v = 0; v < tbl.size(); v++) begin
      plen = tbl[v].n;
      for (int i = 0; i < tbl[v].n; i++) pbuf[i] = tbl[v].w[i];
      load_buf();
      start_run();
      run_instr(tbl[v].cyc / 2);
      check($sformatf("tbl%0d.acc", v), 32'(acc), 32'(tbl[v].acc));
      check($sformatf("tbl%0d.pc", v), 32'(pc), 32'(tbl[v].pc));
      check($sformatf("tbl%0d.halted", v), {30'd0, halted, running}, {30'd0, tbl[v].hlt, !tbl[v].hlt});
      check($sformatf("tbl%0d.flags", v), {29'd0, eq, gt, lt}, {29'd0, tbl[v].flg});
      check($sformatf("tbl%0d.za", v), 32'(za), 32'(tbl[v].acc == 8'h00));
`ifdef PARAM_CPU_CARRY_EN
      check($sformatf("tbl%0d.cy", v), 32'(cy), 32'(tbl[v].cy));
`endif
    end

    // ---- HALT is reached exactly 8 cycles after start ----
    pbuf[0] = 16'h1005; pbuf[1] = 16'h2003; pbuf[2] = 16'h3000; pbuf[3] = 16'hF000;
    plen = 4;
    load_buf();
    start_run();
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("halt_cyc7", {30'd0, halted, running}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("halt_cyc8", {30'd0, halted, running}, 32'd2);
    check("halt_cyc8.pc_acc", {20'd0, 4'(pc), acc}, {20'd0, 4'd3, 8'h08});
    model_run(4);

    // ---- flags after each CMP ----
    pbuf[0] = 16'h1007; pbuf[1] = 16'h2007; pbuf[2] = 16'h8000;
    pbuf[3] = 16'h1009; pbuf[4] = 16'h8000; pbuf[5] = 16'hF000;
    plen = 6;
    load_buf();
    start_run();
    run_instr(3);
    check("cmp1.flags", {29'd0, eq, gt, lt}, 32'd4);
    run_instr(3);
    check("cmp2.flags", {29'd0, eq, gt, lt}, 32'd2);

    // ---- load_full and no wrap on the 17th write ----
    en = 1'b0; @(negedge clk);
    en = 1'b1; @(negedge clk);
    m_pc = 0; m_wptr = 0; m_halt = 0;
    for (int i = 0; i < 17; i++) begin
      we_IM = 1'b1;
      codein = (i == 0) ? 16'h1011 : (i == 1) ? 16'hF000 : (i == 16) ? 16'h10EE : 16'h0000;
      @(negedge clk);
      if (m_wptr < DEPTH) begin m_mem[m_wptr] = codein; m_wptr++; end
      if (i == 14) check("load_full_15", 32'(load_full), 32'd0);
      if (i == 15) check("load_full_16", 32'(load_full), 32'd1);
      if (i == 16) check("load_full_17", 32'(load_full), 32'd1);
    end
    we_IM = 1'b0;
    start_run();
    run_instr(2);
    check("no_wrap.acc", 32'(acc), 32'h11);
    check("no_wrap.pc_halt", {27'd0, pc, halted}, {27'd0, 4'd1, 1'b1});

    // ---- pc wraps 15 -> 0 ----
    for (int i = 0; i < 16; i++) pbuf[i] = 16'h0000;
    plen = 16;
    load_buf();
    start_run();
    run_instr(15);
    check("wrap.pc15", {27'd0, pc, running}, {27'd0, 4'd15, 1'b1});
    run_instr(1);
    check("wrap.pc0", {27'd0, pc, running}, {27'd0, 4'd0, 1'b1});

    // ---- rst in the EXEC cycle of an ADD ----
    pbuf[0] = 16'h1005; pbuf[1] = 16'h2003; pbuf[2] = 16'h3000; pbuf[3] = 16'hF000;
    plen = 4;
    load_buf();
    start_run();
    run_instr(2);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("rst_exec");
    @(negedge clk);
    check("rst_exec.acc_held", 32'(acc), 32'd0);
    rst = 1'b0;
    model_reset();
    plen = 0;
    load_buf();
    start_run();
    run_instr(4);
    check("rerun.acc", 32'(acc), 32'h08);
    check("rerun.pc_halt", {27'd0, pc, halted}, {27'd0, 4'd3, 1'b1});

    // ---- random programs against the reference model ----
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) pbuf[i] = 16'($urandom);
      plen = 16;
      load_buf();
      start_run();
      run_instr($urandom_range(1, 24));
      check_model($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DATA_W, default 8: width of registers A, B and the ALU datapath, minimum 8.
REQ-002 Parameter IM_AW, default 4: instruction-memory address width; depth is 2^IM_AW words of 16 bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  block enable; low forces IDLE.
REQ-006 we_IM  input  1  instruction-memory write strobe, sampled per clock.
REQ-007 codein  input  16  instruction word written when we_IM=1.
REQ-008 immd  input  12  reserved immediate bus, sampled but unused; jump targets come from instr[IM_AW-1:0].
REQ-009 start  input  1  begins execution at pc=0.
REQ-010 za, zb  output  1 each  combinational (A==0), (B==0).
REQ-011 eq, gt, lt  output  1 each  registered unsigned compare flags.
REQ-012 pc  output  IM_AW  current program counter.
REQ-013 acc  output  DATA_W  register A.
REQ-014 running, halted, load_full  output  1 each  status.

Function
REQ-015 FSM states: IDLE, LOAD, FETCH, EXEC, HALT. Transitions: IDLE->LOAD on en=1; LOAD->FETCH on start=1; FETCH->EXEC always; EXEC->FETCH, or ->HALT on opcode F; any state->IDLE on en=0.
REQ-016 In LOAD, we_IM=1 writes codein to IM[wptr], then wptr increments; at 2^IM_AW writes load_full=1, and further writes are ignored with no wrap.
REQ-017 we_IM outside LOAD is ignored; we_IM and start asserted in the same LOAD cycle complete the write, then enter FETCH.
REQ-018 Each instruction takes 2 cycles: FETCH registers IM[pc], EXEC updates state and pc.
REQ-019 Opcodes (instr[15:12]): 0 NOP; 1 LDA A<=zero-extended instr[7:0]; 2 LDB likewise for B; 3 ADD A<=A+B; 4 SUB A<=A-B; 5 AND; 6 OR; 7 XOR; 8 CMP sets eq/gt/lt from A vs B, A unchanged; 9 JMP pc<=instr[IM_AW-1:0]; A JZ jump if za else pc+1; B SWAP A<->B; C SHL A; D SHR A (zero fill); E NOP; F HALT.
REQ-020 All arithmetic is modulo 2^DATA_W; pc increments modulo 2^IM_AW and wraps from 2^IM_AW-1 to 0.
REQ-021 eq/gt/lt change only on CMP, with exactly one of the three set after any CMP.
REQ-022 running=1 in FETCH and EXEC; halted=1 in HALT; HALT is left only via en=0 or rst.
REQ-023 en=0 sets pc=0 and wptr=0 and clears load_full; A, B, flags and IM contents are retained.

Reset
REQ-024 rst=1 immediately sets state IDLE, pc=0, wptr=0, A=B=0, eq=gt=lt=0, running=halted=load_full=0; za=zb=1 as a consequence.
REQ-025 IM contents are not cleared by rst; rst asserted mid-EXEC aborts the instruction with no partial register update.

Configuration
REQ-026 Macro PARAM_CPU_CARRY_EN defined: adds output cy (1 bit, reset 0); ADD sets cy to the carry-out, SUB to the borrow, SHL to the bit shifted out of the MSB, SHR to the bit shifted out of the LSB; other opcodes hold cy.
REQ-027 PARAM_CPU_CARRY_EN undefined: port cy and its logic are absent, and all other behaviour is identical.

Verification
REQ-028 Load 1005,2003,3000,F000, then start -> acc=0x08, halted=1, pc=3, za=0, 8 cycles from start to HALT.
REQ-029 Load 1002,2005,4000,F000 -> acc=0xFD; with PARAM_CPU_CARRY_EN, cy=1.
REQ-030 Load 1007,2007,8000,1009,8000,F000 -> eq=1 after the first CMP; gt=1, eq=lt=0 after the second.
REQ-031 Write 17 words at default IM_AW -> load_full=1 after the 16th write; 17th ignored, IM[0] unchanged.
REQ-032 Sixteen 0000 words -> pc wraps 15->0, running stays 1; program 1000,A005 -> JZ taken, pc=5.
REQ-033 Assert rst mid-EXEC of an ADD -> all outputs reach reset values without a clock edge and acc=0; IM readback unchanged after reload of pc.
